// File: rtl/vote_result_reporter.sv
// Vote result reporter: snapshots four 8-bit tallies on a start request,
// decides the winner, and sends a 7-byte 8N1 frame (LSB first) on tx:
// A5, cand1..cand4, {5'b0,winner}, XOR checksum of the six bytes before it.
//
// Handshake: a start is accepted on a rising edge where start=1 and busy=0.
// A start seen while busy=1 is dropped, not queued. busy stays high from the
// cycle after acceptance until the last stop bit ends. done then pulses for
// one cycle with busy=0, so a start in that same cycle is accepted.
module vote_result_reporter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] cand1_vote,
    input  logic [7:0] cand2_vote,
    input  logic [7:0] cand3_vote,
    input  logic [7:0] cand4_vote,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [2:0] winner,
    output logic [2:0] o_dbg_state
);
    localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    // The stop bit spends CLKS_PER_BIT-1 cycles in STOP_BIT. Its final cycle
    // is spent in NEXT_BYTE, so the stop bit is still exactly CLKS_PER_BIT long.
    localparam logic [BW-1:0] STOP_LAST = BW'(CLKS_PER_BIT - 2);
    localparam logic [7:0]    HEADER    = 8'hA5;
    localparam logic [2:0]    LAST_IDX  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START_BIT = 3'd1,
        S_DATA_BITS = 3'd2,
        S_STOP_BIT  = 3'd3,
        S_NEXT_BYTE = 3'd4
    } state_t;

    state_t        r_state, w_state_next;
    logic [BW-1:0] r_baud, w_baud_next;
    logic [2:0]    r_bit, w_bit_next;
    logic [2:0]    r_byte_idx, w_byte_idx_next;
    logic [7:0]    r_shift, w_shift_next;
    logic          r_tx, w_tx_next;
    logic          r_busy, w_busy_next;
    logic          r_done, w_done_next;
    logic [2:0]    r_winner, w_winner_next;
    logic [7:0]    r_c1, r_c2, r_c3, r_c4;
    logic [7:0]    w_c1_next, w_c2_next, w_c3_next, w_c4_next;
    logic [2:0]    w_winner_in;
    logic [2:0]    w_idx_inc;
    logic [7:0]    w_checksum;
    logic [7:0]    w_next_byte;

    // Unique maximum gives its 1-based index; any shared maximum gives 0.
    function automatic logic [2:0] pick_winner(input logic [7:0] v1, input logic [7:0] v2,
                                               input logic [7:0] v3, input logic [7:0] v4);
        logic [7:0] m;
        logic [2:0] n;
        logic [2:0] idx;
        m = v1;
        if (v2 > m) m = v2;
        if (v3 > m) m = v3;
        if (v4 > m) m = v4;
        n   = 3'd0;
        idx = 3'd0;
        if (v1 == m) begin n = n + 3'd1; idx = 3'd1; end
        if (v2 == m) begin n = n + 3'd1; idx = 3'd2; end
        if (v3 == m) begin n = n + 3'd1; idx = 3'd3; end
        if (v4 == m) begin n = n + 3'd1; idx = 3'd4; end
        return (n == 3'd1) ? idx : 3'd0;
    endfunction

    // The winner is decided from the same values latched into the snapshot.
    // It is registered on the acceptance edge, well before byte 5 needs it.
    assign w_winner_in = pick_winner(cand1_vote, cand2_vote, cand3_vote, cand4_vote);
    assign w_idx_inc   = r_byte_idx + 3'd1;

    // Checksum and next-byte selection, both taken from the snapshot.
    always_comb begin
        w_checksum = HEADER ^ r_c1 ^ r_c2 ^ r_c3 ^ r_c4 ^ {5'b0, r_winner};
        case (w_idx_inc)
            3'd1:    w_next_byte = r_c1;
            3'd2:    w_next_byte = r_c2;
            3'd3:    w_next_byte = r_c3;
            3'd4:    w_next_byte = r_c4;
            3'd5:    w_next_byte = {5'b0, r_winner};
            3'd6:    w_next_byte = w_checksum;
            default: w_next_byte = HEADER;
        endcase
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        w_state_next    = r_state;
        w_baud_next     = r_baud;
        w_bit_next      = r_bit;
        w_byte_idx_next = r_byte_idx;
        w_shift_next    = r_shift;
        w_tx_next       = r_tx;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        w_winner_next   = r_winner;
        w_c1_next       = r_c1;
        w_c2_next       = r_c2;
        w_c3_next       = r_c3;
        w_c4_next       = r_c4;
        case (r_state)
            S_IDLE: begin
                if (start && !r_busy) begin
                    w_state_next    = S_START_BIT;
                    w_baud_next     = '0;
                    w_bit_next      = 3'd0;
                    w_byte_idx_next = 3'd0;
                    w_shift_next    = HEADER;
                    w_tx_next       = 1'b0;
                    w_busy_next     = 1'b1;
                    w_winner_next   = w_winner_in;
                    w_c1_next       = cand1_vote;
                    w_c2_next       = cand2_vote;
                    w_c3_next       = cand3_vote;
                    w_c4_next       = cand4_vote;
                end
            end
            S_START_BIT: begin
                if (r_baud == BAUD_LAST) begin
                    w_state_next = S_DATA_BITS;
                    w_baud_next  = '0;
                    w_tx_next    = r_shift[0];
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            S_DATA_BITS: begin
                if (r_baud == BAUD_LAST) begin
                    w_baud_next = '0;
                    if (r_bit == 3'd7) begin
                        w_state_next = S_STOP_BIT;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_bit_next   = r_bit + 3'd1;
                        w_shift_next = {1'b0, r_shift[7:1]};
                        w_tx_next    = r_shift[1];
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            S_STOP_BIT: begin
                if (r_baud == STOP_LAST) begin
                    w_state_next = S_NEXT_BYTE;
                    w_baud_next  = '0;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            S_NEXT_BYTE: begin
                if (r_byte_idx < LAST_IDX) begin
                    w_state_next    = S_START_BIT;
                    w_byte_idx_next = w_idx_inc;
                    w_shift_next    = w_next_byte;
                    w_bit_next      = 3'd0;
                    w_tx_next       = 1'b0;
                end else begin
                    w_state_next = S_IDLE;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    // State, counters, snapshot and output registers; reset parks the line idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit      <= 3'd0;
            r_byte_idx <= 3'd0;
            r_shift    <= 8'd0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_winner   <= 3'd0;
            r_c1       <= 8'd0;
            r_c2       <= 8'd0;
            r_c3       <= 8'd0;
            r_c4       <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_baud     <= w_baud_next;
            r_bit      <= w_bit_next;
            r_byte_idx <= w_byte_idx_next;
            r_shift    <= w_shift_next;
            r_tx       <= w_tx_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_winner   <= w_winner_next;
            r_c1       <= w_c1_next;
            r_c2       <= w_c2_next;
            r_c3       <= w_c3_next;
            r_c4       <= w_c4_next;
        end
    end

    assign tx          = r_tx;
    assign busy        = r_busy;
    assign done        = r_done;
    assign winner      = r_winner;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vote_result_reporter.sv
// Directed bench for vote_result_reporter with CLKS_PER_BIT=4.
// A frame is 7 bytes x 10 bits x 4 cycles = 280 cycles; done arrives in cycle 281.
module tb_vote_result_reporter;
    localparam int CPB = 4;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] cand1_vote, cand2_vote, cand3_vote, cand4_vote;
    logic       tx, busy, done;
    logic [2:0] winner;
    logic [2:0] o_dbg_state;

    int checks;
    int failures;

    vote_result_reporter #(.CLKS_PER_BIT(CPB)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .cand1_vote (cand1_vote),
        .cand2_vote (cand2_vote),
        .cand3_vote (cand3_vote),
        .cand4_vote (cand4_vote),
        .tx         (tx),
        .busy       (busy),
        .done       (done),
        .winner     (winner),
        .o_dbg_state(o_dbg_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic set_cands(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        cand1_vote = a;
        cand2_vote = b;
        cand3_vote = c;
        cand4_vote = d;
    endtask

    // Start pulse accepted at the next rising edge; returns just after it.
    task automatic launch(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
        @(negedge clock);
        set_cands(a, b, c, d);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Samples cycles 1..281 after an acceptance edge and checks the whole frame.
    task automatic check_frame(input logic [55:0] exp_bytes, input logic [2:0] exp_win,
                               input bit disturb, input string name);
        logic tx_log   [0:281];
        logic busy_log [0:281];
        logic done_log [0:281];
        int   bad_tx, bad_busy, bad_done;
        for (int n = 1; n <= 281; n++) begin
            @(negedge clock);
            tx_log[n]   = tx;
            busy_log[n] = busy;
            done_log[n] = done;
            if (disturb && n == 100) begin
                set_cands(8'd50, 8'd60, 8'd70, 8'd80);
                start = 1'b1;
            end
            if (disturb && n == 101) start = 1'b0;
        end
        bad_tx = 0;
        bad_busy = 0;
        bad_done = 0;
        for (int n = 1; n <= 280; n++) begin
            int b, j;
            logic [7:0] eb;
            logic e;
            b  = (n - 1) / 40;
            j  = ((n - 1) % 40) / 4;
            eb = exp_bytes[55 - 8*b -: 8];
            if (j == 0) e = 1'b0;
            else if (j == 9) e = 1'b1;
            else e = eb[j-1];
            if (tx_log[n] !== e) bad_tx++;
            if (busy_log[n] !== 1'b1) bad_busy++;
            if (done_log[n] !== 1'b0) bad_done++;
        end
        if (tx_log[281] !== 1'b1) bad_tx++;
        if (busy_log[281] !== 1'b0) bad_busy++;
        if (done_log[281] !== 1'b1) bad_done++;

        checks++;
        if (bad_tx !== 0) begin
            failures++;
            $display("FAIL %s tx_wave: %0d bad cycles, required 0", name, bad_tx);
        end
        checks++;
        if (bad_busy !== 0) begin
            failures++;
            $display("FAIL %s busy_window: %0d bad cycles, required 0", name, bad_busy);
        end
        checks++;
        if (bad_done !== 0) begin
            failures++;
            $display("FAIL %s done_pulse: %0d bad cycles, required 0", name, bad_done);
        end
        for (int b = 0; b < 7; b++) begin
            logic [7:0] got;
            logic [7:0] eb;
            eb = exp_bytes[55 - 8*b -: 8];
            for (int j = 1; j <= 8; j++) got[j-1] = tx_log[1 + b*40 + j*4 + 2];
            checks++;
            if (got !== eb) begin
                failures++;
                $display("FAIL %s byte%0d: got %02h required %02h", name, b, got, eb);
            end
        end
        checks++;
        if (winner !== exp_win) begin
            failures++;
            $display("FAIL %s winner: got %0d required %0d", name, winner, exp_win);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        set_cands(8'd0, 8'd0, 8'd0, 8'd0);
        #1 reset = 1'b1;
        #2;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || winner !== 3'd0 || o_dbg_state !== 3'd0) begin
            failures++;
            $display("FAIL reset_state: tx=%b busy=%b done=%b winner=%0d state=%0d required 1 0 0 0 0",
                     tx, busy, done, winner, o_dbg_state);
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: tx=%b busy=%b done=%b required 1 0 0", tx, busy, done);
        end
    endtask

    // Start held high across reset release is taken on the first free edge.
    task automatic test_release_with_start();
        @(negedge clock);
        reset = 1'b1;
        set_cands(8'd1, 8'd2, 8'd3, 8'd9);
        start = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1 start = 1'b0;
        check_frame(56'hA5_01_02_03_09_04_A8, 3'd4, 1'b0, "release_start");
    endtask

    task automatic test_tie();
        launch(8'd3, 8'd7, 8'd2, 8'd7);
        check_frame(56'hA5_03_07_02_07_00_A4, 3'd0, 1'b0, "tie");
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL tie_done_width: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_all_zero();
        launch(8'd0, 8'd0, 8'd0, 8'd0);
        check_frame(56'hA5_00_00_00_00_00_A5, 3'd0, 1'b0, "all_zero");
    endtask

    // Inputs change and start pulses mid-frame; frame and winner must not move.
    task automatic test_ignore_during_frame();
        int bad;
        launch(8'd1, 8'd2, 8'd3, 8'd9);
        check_frame(56'hA5_01_02_03_09_04_A8, 3'd4, 1'b1, "ignore_start");
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (busy !== 1'b0 || done !== 1'b0 || tx !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL ignore_no_second_frame: %0d active cycles, required 0", bad);
        end
        checks++;
        if (winner !== 3'd4) begin
            failures++;
            $display("FAIL winner_hold: got %0d required 4", winner);
        end
    endtask

    task automatic test_mid_frame_reset();
        int bad;
        launch(8'd1, 8'd2, 8'd3, 8'd9);
        repeat (130) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || winner !== 3'd0 || o_dbg_state !== 3'd0) begin
            failures++;
            $display("FAIL midreset_async: tx=%b busy=%b done=%b winner=%0d state=%0d required 1 0 0 0 0",
                     tx, busy, done, winner, o_dbg_state);
        end
        @(negedge clock);
        reset = 1'b0;
        bad = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            if (busy !== 1'b0 || done !== 1'b0 || tx !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL midreset_quiet: %0d active cycles, required 0", bad);
        end
        launch(8'd3, 8'd7, 8'd2, 8'd7);
        check_frame(56'hA5_03_07_02_07_00_A4, 3'd0, 1'b0, "after_reset");
    endtask

    // Start held high: the second frame starts in the cycle after done.
    task automatic test_back_to_back();
        @(negedge clock);
        set_cands(8'h10, 8'h20, 8'h1F, 8'h00);
        start = 1'b1;
        @(posedge clock);
        check_frame(56'hA5_10_20_1F_00_02_88, 3'd2, 1'b0, "b2b_first");
        set_cands(8'hFF, 8'hFE, 8'h00, 8'h80);
        @(posedge clock);
        #1 start = 1'b0;
        check_frame(56'hA5_FF_FE_00_80_01_25, 3'd1, 1'b0, "b2b_second");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_release_with_start();
        test_tie();
        test_all_zero();
        test_ignore_during_frame();
        test_mid_frame_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vote_result_reporter.md
VOTE_RESULT_REPORTER -- requirements
Module: vote_result_reporter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Port: clock  input  1  single system clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to transmit one result frame; sampled on rising clock edge.
REQ-005 Port: cand1_vote, cand2_vote, cand3_vote, cand4_vote  input  8 each  current vote tallies from the vote logger.
REQ-006 Port: tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-007 Port: busy  output  1  high while a frame is in progress.
REQ-008 Port: done  output  1  one-cycle pulse at frame completion.
REQ-009 Port: winner  output  3  registered result: 1..4 = unique maximum candidate, 0 = tie for maximum.

Function
REQ-010 Start is accepted only when busy=0 and start=1 at a rising edge; start while busy=1 is ignored and not queued.
REQ-011 On acceptance, all four tallies are snapshotted into internal registers; later input changes do not affect the frame.
REQ-012 Winner is computed from the snapshot, registered to the winner output, and held until the next accepted start or reset.
REQ-013 Winner rule: 8-bit unsigned compare; exactly one candidate holding the maximum -> its index; two or more sharing the maximum (including all zero) -> 0.
REQ-014 Frame is 7 bytes in order: 0xA5 header, cand1, cand2, cand3, cand4, {5'b0,winner}, checksum.
REQ-015 Checksum is the bitwise XOR of the six preceding bytes, header included.
REQ-016 Each byte is one start bit (0), 8 data bits LSB first, and one stop bit (1); each bit holds tx for exactly CLKS_PER_BIT cycles.
REQ-017 Bytes are back-to-back: the next start bit begins in the cycle after the previous stop bit ends; no inter-byte idle.
REQ-018 Latency: busy=1 and tx=0 (header start bit) in the first cycle after the acceptance edge.
REQ-019 Frame length is exactly 70*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the last stop bit.
REQ-020 In the cycle after the last stop bit ends, busy=0 and done=1 for exactly one cycle; tx stays high.
REQ-021 A start asserted in the same cycle done=1 is accepted, because busy=0 in that cycle.
REQ-022 FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT, NEXT_BYTE.
  - IDLE -> START_BIT on acceptance.
  - START_BIT -> DATA_BITS after CLKS_PER_BIT cycles.
  - DATA_BITS -> STOP_BIT after 8 bits.
  - STOP_BIT -> NEXT_BYTE after CLKS_PER_BIT cycles.
  - NEXT_BYTE -> START_BIT when the byte index is below 6; otherwise -> IDLE with done pulse.
  - NEXT_BYTE consumes no tx time: the index increments in the same cycle the stop bit completes.
REQ-023 The baud counter is wide enough for CLKS_PER_BIT-1 with no wrap; the bit counter covers 0..7; the byte index covers 0..6.
REQ-024 tx, busy and done are driven from registers (glitch-free).

Reset
REQ-025 Reset asserted asynchronously forces, without waiting for a clock edge: tx=1, busy=0, done=0, winner=0, FSM=IDLE, all counters and snapshots 0.
REQ-026 Reset mid-frame aborts the frame with no done pulse; after release, no transmission occurs until a new start is accepted.
REQ-027 Release of reset with start held high is accepted at the first rising edge where reset=0.

Verification (CLKS_PER_BIT=4)
REQ-028 Counts 1,2,3,9 with start pulse -> winner=4; tx bytes A5,01,02,03,09,04,A8; done at cycle 281 after acceptance.
REQ-029 Counts 3,7,2,7 -> winner=0 (tie); bytes A5,03,07,02,07,00,A4.
REQ-030 All counts 0 -> winner=0; bytes A5,00,00,00,00,00,A5.
REQ-031 Change inputs and pulse start during the frame -> frame bytes unchanged, second start ignored, exactly one done pulse.
REQ-032 Assert reset during byte 3 -> tx=1 and busy=0 immediately, no done; a new start then yields a complete, correct frame.
REQ-033 Start held high continuously -> frames repeat; the next header start bit begins in the cycle after done, and each frame decodes correctly.
